// File: rtl/if_id_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset PC, bubble
// encoding, fetch FSM encodings and the wrapping PC incrementer.
package if_id_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // 32-bit unsigned wrap: 32'hFFFF_FFFC + 4 yields 0
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch over a req/ack memory handshake plus the IF/ID pipeline
// register, with a one-entry skid buffer for words acked during a stall.
module if_id_fetch_stage
    import if_id_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_buf;
    logic [31:0]  r_instr_id;
    logic [31:0]  r_pc_plus4_id;
    logic         r_valid_id;

    logic         w_req_active;
    logic         w_outstanding;

    // A request is live in FETCH and DRAIN; reset must kill it in the same cycle
    assign w_req_active  = (r_state == FETCH) || (r_state == DRAIN);
    assign w_outstanding = w_req_active && !imem_ack;

    assign imem_req    = w_req_active && !rst;
    assign imem_addr   = r_req_addr;
    assign instr_id    = r_instr_id;
    assign pc_plus4_id = r_pc_plus4_id;
    assign valid_id    = r_valid_id;

    // Fetch FSM, PC, skid buffer and IF/ID register; priority rst > redirect > stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_buf         <= NOP_INSTR;
            r_instr_id    <= NOP_INSTR;
            r_pc_plus4_id <= 32'd0;
            r_valid_id    <= 1'b0;
        end else if (redirect_valid) begin
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
            r_pc       <= redirect_pc;
            r_buf      <= NOP_INSTR;
            // Any acked word this edge is dropped; an unacked request must drain first
            if (w_outstanding) begin
                r_state <= DRAIN;
            end else begin
                r_state    <= FETCH;
                r_req_addr <= redirect_pc;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_pc       <= pc_inc(r_pc);
                        r_req_addr <= pc_inc(r_pc);
                        if (stall) begin
                            r_buf   <= imem_rdata;
                            r_state <= FULL;
                        end else begin
                            r_instr_id    <= imem_rdata;
                            r_pc_plus4_id <= pc_inc(r_req_addr);
                            r_valid_id    <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_instr_id <= NOP_INSTR;
                        r_valid_id <= 1'b0;
                    end
                end
                FULL: begin
                    // r_pc already points one past the buffered word
                    if (!stall) begin
                        r_instr_id    <= r_buf;
                        r_pc_plus4_id <= r_pc;
                        r_valid_id    <= 1'b1;
                        r_req_addr    <= r_pc;
                        r_state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        r_req_addr <= r_pc;
                        r_state    <= FETCH;
                    end
                    if (!stall) begin
                        r_instr_id <= NOP_INSTR;
                        r_valid_id <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= FETCH;
                    r_req_addr <= r_pc;
                    r_instr_id <= NOP_INSTR;
                    r_valid_id <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: the bench plays the instruction memory
// cycle by cycle and checks outputs 1 time unit after each rising edge.
module tb_if_id_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;

    int n_assert;
    int n_fail;

    if_id_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_id       (instr_id),
        .pc_plus4_id    (pc_plus4_id),
        .valid_id       (valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                          input logic valid);
        chk({tag, ".instr"}, instr_id, instr);
        chk({tag, ".pc4"}, pc_plus4_id, pc4);
        chk({tag, ".valid"}, {31'd0, valid_id}, {31'd0, valid});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;

        // Reset
        #1;
        chk("rst_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        chk_id("reset", 32'h0000_0000, 32'h0000_0000, 1'b0);
        chk("rst_req_low2", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk_req("first_req", 1'b1, 32'h0040_0000);

        // Zero-wait memory, data = address
        imem_ack = 1'b1; imem_rdata = 32'h0040_0000;
        tick();
        chk_id("zw0", 32'h0040_0000, 32'h0040_0004, 1'b1);
        chk_req("zw0", 1'b1, 32'h0040_0004);
        imem_rdata = 32'h0040_0004;
        tick();
        chk_id("zw1", 32'h0040_0004, 32'h0040_0008, 1'b1);
        chk_req("zw1", 1'b1, 32'h0040_0008);

        // Stall in the same cycle as ack of 0x00400008
        imem_rdata = 32'h0040_0008; stall = 1'b1;
        tick();
        chk_id("stall_hold", 32'h0040_0004, 32'h0040_0008, 1'b1);
        chk_req("stall_full", 1'b0, 32'h0);
        imem_ack = 1'b0; imem_rdata = 32'hFFFF_0000;
        tick();
        chk_id("stall_hold2", 32'h0040_0004, 32'h0040_0008, 1'b1);
        chk_req("stall_full2", 1'b0, 32'h0);
        stall = 1'b0;
        tick();
        chk_id("unstall", 32'h0040_0008, 32'h0040_000C, 1'b1);
        chk_req("unstall", 1'b1, 32'h0040_000C);

        // Wait states: two bubbles, address held
        tick();
        chk_id("wait0", 32'h0000_0000, 32'h0040_000C, 1'b0);
        chk_req("wait0", 1'b1, 32'h0040_000C);
        tick();
        chk_id("wait1", 32'h0000_0000, 32'h0040_000C, 1'b0);
        chk_req("wait1", 1'b1, 32'h0040_000C);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk_id("wait_ack", 32'hDEAD_BEEF, 32'h0040_0010, 1'b1);
        chk_req("wait_ack", 1'b1, 32'h0040_0010);

        // Redirect while a request is pending: drain, discard stale word
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        tick();
        chk_id("redir", 32'h0000_0000, 32'h0040_0010, 1'b0);
        chk_req("drain0", 1'b1, 32'h0040_0010);
        redirect_valid = 1'b0;
        tick();
        chk_id("drain1", 32'h0000_0000, 32'h0040_0010, 1'b0);
        chk_req("drain1", 1'b1, 32'h0040_0010);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        chk_id("drain_ack", 32'h0000_0000, 32'h0040_0010, 1'b0);
        chk_req("drain_ack", 1'b1, 32'h0040_0100);
        imem_rdata = 32'h1111_1111;
        tick();
        chk_id("target", 32'h1111_1111, 32'h0040_0104, 1'b1);

        // Redirect and stall together, ack coincident: redirect wins, go straight to FETCH
        redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h0040_0200;
        imem_rdata = 32'h2222_2222;
        tick();
        chk_id("redir_stall", 32'h0000_0000, 32'h0040_0104, 1'b0);
        chk_req("redir_stall", 1'b1, 32'h0040_0200);
        redirect_valid = 1'b0; stall = 1'b0; imem_rdata = 32'h3333_3333;
        tick();
        chk_id("redir_stall_t", 32'h3333_3333, 32'h0040_0204, 1'b1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
        redirect_valid = 1'b0; imem_rdata = 32'h4444_4444;
        tick();
        chk_id("wrap", 32'h4444_4444, 32'h0000_0000, 1'b1);
        chk_req("wrap_next", 1'b1, 32'h0000_0000);

        // Unaligned redirect target is forwarded unchanged
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0302;
        tick();
        chk_req("unaligned", 1'b1, 32'h0040_0302);
        redirect_valid = 1'b0; imem_ack = 1'b0;
        tick();
        chk_req("pending", 1'b1, 32'h0040_0302);

        // Reset in the middle of a wait
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_id("midrst", 32'h0000_0000, 32'h0000_0000, 1'b0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        #1;
        chk_req("restart", 1'b1, 32'h0040_0000);
        tick();
        chk_id("restart", 32'h5555_5555, 32'h0040_0004, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
